// File: rtl/instr_wb_pkg.sv
// Shared types and defaults for the instrumented Wishbone B4 pipelined master.
//   wb_req_t : one bus transfer (write enable, address, write data, byte select)
//   state_e  : bus-cycle state (IDLE, ACTIVE, one-cycle ABORT after a timeout)
package instr_wb_pkg;

  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned DEF_TIMEOUT         = 64;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_wb_master.sv
// Instrumented Wishbone B4 pipelined master.
// Turns valid/ready requests into pipelined Wishbone transfers, returns the
// acknowledged data in issue order and reports protocol errors, timeouts and
// traffic statistics.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake
//   req_we_i/adr_i/dat_i/sel_i    request fields, captured on accept
//   resp_valid_o / resp_dat_o     one pulse per acknowledged transfer, data held
//   wb_*                          Wishbone B4 pipelined master interface
//   clear_i                       clears the sticky error flags
//   protocol_error_o, timeout_o   sticky error flags
//   issued_count_o                transfers issued (stb && !stall), wrapping
//   stall_cycles_o                cycles with stb && stall, wrapping
module instr_wb_master
  import instr_wb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned TIMEOUT         = DEF_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_dat_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        clear_i,
  output logic        protocol_error_o,
  output logic        timeout_o,
  output logic [31:0] issued_count_o,
  output logic [31:0] stall_cycles_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [OW:0]   MAX_OUT  = (OW + 1)'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          stb_q, stb_d;
  wb_req_t       req_q, req_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_dat_q, resp_dat_d;
  logic          proto_err_q, proto_err_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   issued_q, issued_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic          cyc;
  logic          issue;
  logic          valid_ack;
  logic          stray_ack;
  logic          aborting;
  logic          req_ready;
  logic          accept;
  logic          timeout_hit;
  logic [OW:0]   in_flight;

  assign aborting  = (state_q == ABORT);
  assign cyc       = stb_q || (outst_q != '0);
  assign issue     = stb_q && !wb_stall_i;
  // An ack only counts when something is outstanding; this also rejects an
  // ack arriving in the same cycle as the very first issue.
  assign valid_ack = wb_ack_i && (outst_q != '0);
  assign stray_ack = wb_ack_i && (outst_q == '0);

  // The strobe currently on the bus counts against the limit, so after an
  // accept outstanding + strobe never exceeds MAX_OUTSTANDING.
  assign in_flight = {1'b0, outst_q} + {{OW{1'b0}}, stb_q};
  assign req_ready = (!stb_q || !wb_stall_i) && (in_flight < MAX_OUT) && !aborting;
  assign accept    = req_valid_i && req_ready;

  // Fires on the cycle the counter would reach TIMEOUT, so cyc is low on the
  // TIMEOUT-th cycle after it rose without any ack.
  assign timeout_hit = cyc && !valid_ack && (tmo_cnt_q == TMO_LAST);

  // Datapath next-state.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    stb_d        = stb_q;
    req_d        = req_q;
    outst_d      = outst_q;
    tmo_cnt_d    = tmo_cnt_q;
    resp_valid_d = valid_ack;
    resp_dat_d   = resp_dat_q;
    proto_err_d  = stray_ack || (proto_err_q && !clear_i);
    timeout_d    = timeout_hit || (timeout_q && !clear_i);
    issued_d     = issued_q + 32'(issue);
    stall_cnt_d  = stall_cnt_q + 32'(stb_q && wb_stall_i);

    if (valid_ack) begin
      resp_dat_d = wb_dat_i;
    end

    // Accept is only possible when the strobe is low or issuing, so the bus
    // fields stay frozen while stalled without an explicit hold term.
    if (accept) begin
      stb_d = 1'b1;
      req_d = '{we: req_we_i, adr: req_adr_i, dat: req_dat_i, sel: req_sel_i};
    end else if (issue) begin
      stb_d = 1'b0;
    end

    unique case ({issue, valid_ack})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    if (!cyc || valid_ack) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    // Abort wins over everything above; a request accepted in this very
    // cycle is dropped together with the rest of the bus cycle.
    if (timeout_hit) begin
      stb_d     = 1'b0;
      outst_d   = '0;
      tmo_cnt_d = '0;
    end
  end

  // Cycle state next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE: begin
        if (timeout_hit) begin
          state_d = ABORT;
        end else if (!stb_d && (outst_d == '0)) begin
          state_d = IDLE;
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      stb_q        <= 1'b0;
      req_q        <= '0;
      outst_q      <= '0;
      tmo_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_dat_q   <= '0;
      proto_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      issued_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      stb_q        <= stb_d;
      req_q        <= req_d;
      outst_q      <= outst_d;
      tmo_cnt_q    <= tmo_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_dat_q   <= resp_dat_d;
      proto_err_q  <= proto_err_d;
      timeout_q    <= timeout_d;
      issued_q     <= issued_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign req_ready_o      = req_ready;
  assign resp_valid_o     = resp_valid_q;
  assign resp_dat_o       = resp_dat_q;
  assign wb_adr_o         = req_q.adr;
  assign wb_dat_o         = req_q.dat;
  assign wb_we_o          = req_q.we;
  assign wb_sel_o         = req_q.sel;
  assign wb_stb_o         = stb_q;
  assign wb_cyc_o         = cyc;
  assign protocol_error_o = proto_err_q;
  assign timeout_o        = timeout_q;
  assign issued_count_o   = issued_q;
  assign stall_cycles_o   = stall_cnt_q;

endmodule
